// File: rtl/pattern_gen.sv
// Video test-pattern source: two-stage pipeline turning raster counters into 24-bit RGB.
// Optional build macro PATGEN_BORDER_EN forces a one-pixel white border over every pattern.
module pattern_gen #(
    parameter logic [11:0] ACTIVE_H       = 12'd1920,
    parameter logic [10:0] ACTIVE_V       = 11'd1080,
    parameter logic [7:0]  FRAMES_PER_PAT = 8'd120,
    parameter logic [11:0] BOX_SIZE       = 12'd64,
    parameter logic [11:0] BOX_STEP       = 12'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [11:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic [2:0]  pat_sel,
    input  logic        auto_en,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [2:0]  pat_cur
);

    localparam logic [11:0] BAR_W      = ACTIVE_H / 12'd8;
    localparam logic [11:0] MAX_X      = ACTIVE_H - BOX_SIZE;
    localparam logic [10:0] BOX_SIZE_Y = BOX_SIZE[10:0];
    localparam logic [10:0] STEP_Y     = BOX_STEP[10:0];
    localparam logic [10:0] MAX_Y      = ACTIVE_V - BOX_SIZE_Y;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] GREY  = 24'h808080;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    logic        hs_1_r;
    logic        vs_1_r;
    logic        de_1_r;
    logic [11:0] hcnt_1_r;
    logic [10:0] vcnt_1_r;

    logic        vsync_prev_r;
    logic [7:0]  frame_cnt_r;
    logic [11:0] box_x_r;
    logic [10:0] box_y_r;
    logic        dir_x_r;
    logic        dir_y_r;

    logic        fe_s;
    logic [2:0]  bar_idx_s;
    logic        in_box_s;
    logic [23:0] pix_s;
    logic [23:0] rgb_s;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Frame event: falling edge of vsync_in against its registered copy.
    assign fe_s = vsync_prev_r & ~vsync_in;

    // Stage 1: register sync, DE and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_1_r   <= 1'b1;
            vs_1_r   <= 1'b1;
            de_1_r   <= 1'b0;
            hcnt_1_r <= 12'd0;
            vcnt_1_r <= 11'd0;
        end else begin
            hs_1_r   <= hsync_in;
            vs_1_r   <= vsync_in;
            de_1_r   <= de_in;
            hcnt_1_r <= hcnt;
            vcnt_1_r <= vcnt;
        end
    end

    // Pattern selection: manual latch or auto-cycle, both only on the frame event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_r <= 1'b1;
            frame_cnt_r  <= 8'd0;
            pat_cur      <= 3'd0;
        end else begin
            vsync_prev_r <= vsync_in;
            if (!auto_en) begin
                frame_cnt_r <= 8'd0;
                if (fe_s) begin
                    pat_cur <= pat_sel;
                end else begin
                    pat_cur <= pat_cur;
                end
            end else if (fe_s) begin
                if (frame_cnt_r == FRAMES_PER_PAT - 8'd1) begin
                    frame_cnt_r <= 8'd0;
                    pat_cur     <= pat_cur + 3'd1;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Box motion: bounce each axis between 0 and ACTIVE-BOX_SIZE, once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x_r <= 12'd0;
            box_y_r <= 11'd0;
            dir_x_r <= 1'b0;
            dir_y_r <= 1'b0;
        end else if (fe_s) begin
            if (!dir_x_r) begin
                if (box_x_r + BOX_STEP >= MAX_X) begin
                    box_x_r <= MAX_X;
                    dir_x_r <= 1'b1;
                end else begin
                    box_x_r <= box_x_r + BOX_STEP;
                end
            end else begin
                if (box_x_r <= BOX_STEP) begin
                    box_x_r <= 12'd0;
                    dir_x_r <= 1'b0;
                end else begin
                    box_x_r <= box_x_r - BOX_STEP;
                end
            end
            if (!dir_y_r) begin
                if (box_y_r + STEP_Y >= MAX_Y) begin
                    box_y_r <= MAX_Y;
                    dir_y_r <= 1'b1;
                end else begin
                    box_y_r <= box_y_r + STEP_Y;
                end
            end else begin
                if (box_y_r <= STEP_Y) begin
                    box_y_r <= 11'd0;
                    dir_y_r <= 1'b0;
                end else begin
                    box_y_r <= box_y_r - STEP_Y;
                end
            end
        end else begin
            box_x_r <= box_x_r;
            box_y_r <= box_y_r;
        end
    end

    // Colour-bar index by threshold compare against multiples of the bar width.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcnt_1_r >= 12'(BAR_W * k)) begin
                bar_idx_s = 3'(k);
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    // Pattern decode from stage-1 counters.
    always_comb begin
        in_box_s = (hcnt_1_r >= box_x_r) && (hcnt_1_r < box_x_r + BOX_SIZE) &&
                   (vcnt_1_r >= box_y_r) && (vcnt_1_r < box_y_r + BOX_SIZE_Y);
        case (pat_cur)
            3'd0:    pix_s = bar_colour(bar_idx_s);
            3'd1:    pix_s = {3{hcnt_1_r[10:3]}};
            3'd2:    pix_s = {3{vcnt_1_r[9:2]}};
            3'd3:    pix_s = ((hcnt_1_r[5:0] == 6'd0) || (vcnt_1_r[5:0] == 6'd0)) ? WHITE : BLACK;
            3'd4:    pix_s = in_box_s ? RED : BLUE;
            3'd5:    pix_s = WHITE;
            3'd6:    pix_s = GREY;
            3'd7:    pix_s = (hcnt_1_r[6] ^ vcnt_1_r[6]) ? WHITE : BLACK;
            default: pix_s = BLACK;
        endcase
    end

`ifdef PATGEN_BORDER_EN
    // Border override on the first/last active column and row.
    always_comb begin
        if ((hcnt_1_r == 12'd0) || (hcnt_1_r == ACTIVE_H - 12'd1) ||
            (vcnt_1_r == 11'd0) || (vcnt_1_r == ACTIVE_V - 11'd1)) begin
            rgb_s = WHITE;
        end else begin
            rgb_s = pix_s;
        end
    end
`else
    assign rgb_s = pix_s;
`endif

    // Stage 2: registered outputs, RGB blanked outside DE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            de_out    <= 1'b0;
            r         <= 8'd0;
            g         <= 8'd0;
            b         <= 8'd0;
        end else begin
            hsync_out <= hs_1_r;
            vsync_out <= vs_1_r;
            de_out    <= de_1_r;
            if (de_1_r) begin
                r <= rgb_s[23:16];
                g <= rgb_s[15:8];
                b <= rgb_s[7:0];
            end else begin
                r <= 8'd0;
                g <= 8'd0;
                b <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: a full-size instance and a 16x16 instance for box motion.
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in, de_in;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [2:0]  pat_sel;
    logic        auto_en;

    logic        hs_o, vs_o, de_o;
    logic [7:0]  r_o, g_o, b_o;
    logic [2:0]  pat_o;
    logic        hs_s, vs_s, de_s;
    logic [7:0]  r_s, g_s, b_s;
    logic [2:0]  pat_s;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        chk;
        logic        sel;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } sb_t;

    sb_t   sbq[$];
    string tagq[$];

    always #5 clk = ~clk;

    pattern_gen #(.FRAMES_PER_PAT(8'd2)) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .hcnt(hcnt), .vcnt(vcnt), .pat_sel(pat_sel), .auto_en(auto_en),
        .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o),
        .r(r_o), .g(g_o), .b(b_o), .pat_cur(pat_o)
    );

    pattern_gen #(.ACTIVE_H(12'd16), .ACTIVE_V(11'd16), .BOX_SIZE(12'd4), .BOX_STEP(12'd4)) dut_s (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .hcnt(hcnt), .vcnt(vcnt), .pat_sel(pat_sel), .auto_en(auto_en),
        .hsync_out(hs_s), .vsync_out(vs_s), .de_out(de_s),
        .r(r_s), .g(g_s), .b(b_s), .pat_cur(pat_s)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] bord(input logic [23:0] c, input int h, input int v,
                                         input int ah, input int av);
`ifdef PATGEN_BORDER_EN
        if (h == 0 || h == ah - 1 || v == 0 || v == av - 1) return 24'hFFFFFF;
`endif
        return c;
    endfunction

    // Drive one cycle of inputs, record the expectation, compare the entry now due.
    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [11:0] h, input logic [10:0] v,
                        input logic c, input logic sel, input logic [23:0] exp, input string tag);
        sb_t   e;
        string t;
        logic [23:0] act;
        logic [2:0]  ctl;
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        hcnt     = h;
        vcnt     = v;
        sbq.push_back('{c, sel, exp, de, hs, vs});
        tagq.push_back(tag);
        @(negedge clk);
        if (sbq.size() >= 2) begin
            e   = sbq.pop_front();
            t   = tagq.pop_front();
            act = e.sel ? {r_s, g_s, b_s} : {r_o, g_o, b_o};
            ctl = e.sel ? {de_s, hs_s, vs_s} : {de_o, hs_o, vs_o};
            if (e.chk) check(t, {8'd0, act}, {8'd0, e.rgb});
            check({t, "_ctl"}, {29'd0, ctl}, {29'd0, e.de, e.hs, e.vs});
        end
    endtask

    task automatic px(input int h, input int v, input logic sel, input logic [23:0] exp,
                      input string tag);
        step(1'b1, 1'b1, 1'b1, 12'(h), 11'(v), 1'b1, sel, exp, tag);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 24'd0, "idle");
    endtask

    task automatic frame();
        step(1'b1, 1'b0, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 24'd0, "fe");
        step(1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 24'd0, "fe");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int box_tbl[8] = '{4, 8, 12, 8, 4, 0, 4, 8};
        int bx;
        reset    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        de_in    = 1'b0;
        hcnt     = 12'd0;
        vcnt     = 11'd0;
        pat_sel  = 3'd0;
        auto_en  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-line with DE high.
        repeat (3) px(100, 10, 1'b0, 24'hFFFFFF, "pre_rst");
        reset = 1'b1;
        #1;
        check("rst_de", {31'd0, de_o}, 32'd0);
        check("rst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
        check("rst_hs", {31'd0, hs_o}, 32'd1);
        check("rst_vs", {31'd0, vs_o}, 32'd1);
        check("rst_pat", {29'd0, pat_o}, 32'd0);
        sbq.delete();
        tagq.delete();
        @(negedge clk);
        reset = 1'b0;
        px(100, 10, 1'b0, 24'hFFFFFF, "post_rst0");
        step(1'b1, 1'b1, 1'b0, 12'd100, 11'd10, 1'b1, 1'b0, 24'd0, "post_rst_de0");
        px(100, 10, 1'b0, 24'hFFFFFF, "post_rst1");
        px(100, 10, 1'b0, 24'hFFFFFF, "post_rst2");

        // Moving box on the 16x16 instance.
        pat_sel = 3'd4;
        for (int k = 0; k < 8; k++) begin
            frame();
            bx = box_tbl[k];
            px(bx, bx, 1'b1, bord(24'hFF0000, bx, bx, 16, 16), $sformatf("box_in%0d", k));
            px(bx + 3, bx + 3, 1'b1, bord(24'hFF0000, bx + 3, bx + 3, 16, 16), $sformatf("box_far%0d", k));
            if (bx + 4 < 16) px(bx + 4, bx, 1'b1, bord(24'h0000FF, bx + 4, bx, 16, 16), $sformatf("box_r%0d", k));
            if (bx > 0) px(bx - 1, bx, 1'b1, bord(24'h0000FF, bx - 1, bx, 16, 16), $sformatf("box_l%0d", k));
        end
        check("pat_box", {29'd0, pat_s}, 32'd4);

        // Colour bars.
        pat_sel = 3'd0;
        frame();
        px(0, 10, 1'b0, 24'hFFFFFF, "bar_h0");
        px(239, 10, 1'b0, 24'hFFFFFF, "bar_h239");
        px(240, 10, 1'b0, 24'hFFFF00, "bar_h240");
        px(480, 10, 1'b0, 24'h00FFFF, "bar_h480");
        px(720, 10, 1'b0, 24'h00FF00, "bar_h720");
        px(960, 10, 1'b0, 24'hFF00FF, "bar_h960");
        px(1200, 10, 1'b0, 24'hFF0000, "bar_h1200");
        px(1679, 10, 1'b0, 24'h0000FF, "bar_h1679");
        px(1919, 10, 1'b0, bord(24'h000000, 1919, 10, 1920, 1080), "bar_h1919");

        // Pattern select change only takes effect at the frame event.
        pat_sel = 3'd3;
        px(64, 5, 1'b0, 24'hFFFFFF, "mid_frame");
        idle();
        check("pat_hold", {29'd0, pat_o}, 32'd0);
        frame();
        check("pat_grid", {29'd0, pat_o}, 32'd3);
        px(64, 5, 1'b0, 24'hFFFFFF, "grid_64_5");
        px(65, 5, 1'b0, 24'h000000, "grid_65_5");
        px(65, 128, 1'b0, 24'hFFFFFF, "grid_65_128");

        pat_sel = 3'd1;
        frame();
        px(1000, 10, 1'b0, 24'h7D7D7D, "hramp");
        pat_sel = 3'd2;
        frame();
        px(500, 1030, 1'b0, 24'h010101, "vramp1030");
        px(500, 1024, 1'b0, 24'h000000, "vramp_wrap");
        pat_sel = 3'd7;
        frame();
        px(64, 5, 1'b0, 24'hFFFFFF, "chk_a");
        px(64, 64, 1'b0, 24'h000000, "chk_b");
        px(200, 100, 1'b0, 24'h000000, "chk_c");
        pat_sel = 3'd6;
        frame();
        px(100, 100, 1'b0, 24'h808080, "grey");
        px(0, 100, 1'b0, bord(24'h808080, 0, 100, 1920, 1080), "grey_h0");

        // Solid white blanked by DE, sync passed through.
        pat_sel = 3'd5;
        frame();
        step(1'b0, 1'b1, 1'b0, 12'd500, 11'd10, 1'b1, 1'b0, 24'd0, "de0_hs0");
        step(1'b1, 1'b0, 1'b0, 12'd500, 11'd10, 1'b1, 1'b0, 24'd0, "de0_vs0");
        step(1'b0, 1'b0, 1'b0, 12'd500, 11'd10, 1'b1, 1'b0, 24'd0, "de0_both");
        px(500, 10, 1'b0, 24'hFFFFFF, "solid");

        // Auto-cycle with two frames per pattern.
        pat_sel = 3'd0;
        frame();
        check("pat_auto0", {29'd0, pat_o}, 32'd0);
        auto_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            frame();
            check($sformatf("auto_fe%0d", i + 1), {29'd0, pat_o}, 32'(((i + 1) / 2) % 8));
        end

        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Video test-pattern source that sits directly downstream of the raster timing generator.
- Consumes the timing generator's counters, sync and data-enable, and emits 24-bit RGB plus delay-matched sync and DE to the output encoder.
- Pattern is selected by register or auto-cycled every N frames.
- Pattern changes and box motion are frame-synchronous, so no mid-frame tearing.

Parameters:
- ACTIVE_H, 12'd1920: active pixels per line.
- ACTIVE_V, 11'd1080: active lines per frame.
- FRAMES_PER_PAT, 8'd120: frames each pattern is shown in auto mode (>=1).
- BOX_SIZE, 12'd64: moving-box edge length in pixels.
- BOX_STEP, 12'd4: box displacement per frame, per axis.

Ports:
- clk  in  1: pixel clock.
- reset  in  1: asynchronous, active-high reset.
- hsync_in  in  1: horizontal sync from timing generator, active-low.
- vsync_in  in  1: vertical sync from timing generator, active-low.
- de_in  in  1: data enable from timing generator.
- hcnt  in  12: horizontal pixel counter.
- vcnt  in  11: vertical line counter.
- pat_sel  in  3: manual pattern select.
- auto_en  in  1: 1 = auto-cycle patterns.
- hsync_out  out  1: hsync_in delayed 2 clk.
- vsync_out  out  1: vsync_in delayed 2 clk.
- de_out  out  1: de_in delayed 2 clk.
- r  out  8: red.
- g  out  8: green.
- b  out  8: blue.
- pat_cur  out  3: pattern currently displayed.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values:
  - hsync_out=1, vsync_out=1, de_out=0, r=g=b=0, pat_cur=0.
  - Frame counter 0; box_x=0, box_y=0; both directions +.
  - vsync_prev=1.
- Reset mid-frame: outputs take reset values immediately. After release the pipeline refills; valid outputs appear on the 2nd clk.
- Latency: exactly 2 clk from inputs to every output. Stage 1 registers sync/DE/counters and decodes the pattern; stage 2 registers RGB.
- RGB is forced to 0 whenever the stage-2 DE is 0.
- Frame event (fe): vsync_in 1->0, detected against the registered vsync_prev. Exactly one single-cycle pulse per frame.
- Pattern latch: pat_cur changes only on fe.
  - auto_en=0: pat_cur<=pat_sel on fe; frame counter held at 0.
  - auto_en=1: frame counter increments on fe. When it equals FRAMES_PER_PAT-1 it wraps to 0 and pat_cur<=pat_cur+1 (mod 8; 7->0).
  - auto_en 1->0: pat_sel is taken at the next fe.
- Patterns (hcnt/vcnt as seen at stage 1):
  - 0 colour bars: 8 bars of width ACTIVE_H/8, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index is found by threshold compare, not a divider.
  - 1 horizontal ramp: r=g=b=hcnt[10:3].
  - 2 vertical ramp: r=g=b=vcnt[9:2]; truncation to 8 bits wraps (vcnt 1024 -> 0).
  - 3 grid: FFFFFF where hcnt[5:0]==0 or vcnt[5:0]==0; else 000000.
  - 4 moving box: FF0000 where box_x<=hcnt<box_x+BOX_SIZE and box_y<=vcnt<box_y+BOX_SIZE; else 0000FF.
  - 5 solid FFFFFF.
  - 6 solid 808080.
  - 7 checkerboard: FFFFFF when hcnt[6]^vcnt[6], else 000000.
- Box motion (updates on every fe regardless of pattern). Per axis, max = ACTIVE-BOX_SIZE:
  - Moving +: if pos+STEP>=max then pos<=max and direction becomes −; else pos+=STEP.
  - Moving −: if pos<=STEP then pos<=0 and direction becomes +; else pos-=STEP.
  - x and y use 12-bit and 11-bit arithmetic respectively, with no overflow when parameters are legal.
- Sync/DE pass through unchanged apart from the delay. Counter values outside the active region are irrelevant because DE masks RGB.

Optional Feature:
- PATGEN_BORDER_EN defined: pixels with DE=1 and hcnt==0, hcnt==ACTIVE_H-1, vcnt==0 or vcnt==ACTIVE_V-1 are forced to FFFFFF, overriding every pattern. Same 2-clk latency.
- PATGEN_BORDER_EN undefined: no override; border logic is absent from the netlist.

Test Plan:
- Reset asserted mid-line with de_in=1 → same cycle: de_out=0, rgb=0, hsync_out=vsync_out=1. After release, de_out follows de_in with 2-clk delay.
- pat_sel=0 latched, de_in=1, vcnt=10, hcnt=0/239/240/1919 → 2 clk later rgb=FFFFFF/FFFFFF/FFFF00/000000.
- pat_sel 0->3 mid-frame → pat_cur stays 0 until the vsync_in falling edge, then 3. Then hcnt=64,vcnt=5 → FFFFFF; hcnt=65,vcnt=5 → 000000.
- auto_en=1, FRAMES_PER_PAT=2, 16 frame events → pat_cur sequence 0,1,1,2,2,…,7,7,0 (changes every 2nd fe; wraps 7->0).
- ACTIVE_H=16, BOX_SIZE=4, BOX_STEP=4, 8 frame events → box_x 4,8,12,8,4,0,4,8 (direction reverses at 12 and 0).
- pat_sel=5, de_in=0 → rgb=000000 while hsync_out/vsync_out mirror inputs 2 clk late. With PATGEN_BORDER_EN and pattern 6, hcnt=0 → FFFFFF.
